decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Pipelined RV32I(+M) instruction decode stage. Sits between fetch and the register-read/issue stage.
//  Accepts {instruction, PC} beats over valid/ready and emits a registered decoded bundle over valid/ready.
//  Bundle: rs1/rs2/rd, sign-extended immediate, op index, format, use flags and an illegal flag.
//  A 2-entry skid buffer decouples backpressure; FLUSH discards in-flight beats on branch redirect.
// PARAMETERS
//  XLEN      32  PC width (IN_PC/OUT_PC); immediate is always 32 bits
//  ENABLE_M  1   1: decode MUL..REMU; 0: M-extension encodings flagged illegal
//  CNT_W     32  width of DECODED_CNT / ILLEGAL_CNT statistics counters
// PORTS
//  CLK          in   1      clock, all state on posedge
//  RSTN         in   1      synchronous active-low reset
//  IN_VALID     in   1      fetch beat valid
//  IN_READY     out  1      stage can accept a beat this cycle
//  IN_INSTR     in   32     raw instruction word
//  IN_PC        in   XLEN   PC of IN_INSTR
//  FLUSH        in   1      discard all buffered and incoming beats
//  OUT_VALID    out  1      decoded bundle valid
//  OUT_READY    in   1      downstream accepts bundle
//  OUT_PC       out  XLEN   PC of bundle
//  OUT_RS1/RS2  out  5      source regs; 0 when format does not use them
//  OUT_RD       out  5      dest reg; 0 for S/B formats
//  OUT_IMM      out  32     sign-extended immediate per format (I,S,B,U,J); 0 for R
//  OUT_FMT      out  3      0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//  OUT_OP       out  6      op index (see BEHAVIOUR)
//  OUT_USE_RS1  out  1      rs1 read required
//  OUT_USE_RS2  out  1      rs2 read required
//  OUT_WR_RD    out  1      writes rd; forced 0 when rd==0
//  OUT_ILLEGAL  out  1      undecodable encoding
//  DECODED_CNT  out  CNT_W  count of bundles handed off (OUT_VALID&OUT_READY), wraps
//  ILLEGAL_CNT  out  CNT_W  count of handed-off bundles with OUT_ILLEGAL=1, wraps
// BEHAVIOUR
//  Reset (RSTN=0 at posedge): both buffer entries empty; OUT_VALID=0; all OUT_* data = 0; counters = 0.
//   IN_READY=0 while RSTN=0, 1 the cycle after release.
//  Accept: IN_VALID&IN_READY. Decode is combinational on IN_INSTR; result written to buffer.
//   Latency 1: bundle visible on OUT_* the cycle after accept when buffer was empty.
//  Buffer: main + skid entry, FIFO order. IN_READY = skid entry empty (registered, not a
//   combinational function of OUT_READY). Throughput 1 beat/cycle when OUT_READY held high.
//   OUT_* data stable while OUT_VALID=1 and OUT_READY=0. Simultaneous accept+handoff keeps occupancy.
//  FLUSH=1: at posedge both entries empty, OUT_VALID=0 next cycle; beat accepted same cycle dropped.
//   The handoff in the FLUSH cycle still counts (downstream saw it). Flush wins over accept.
//  OUT_OP: 0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5-10 BEQ BNE BLT BGE BLTU BGEU,
//   11-15 LB LH LW LBU LHU, 16-18 SB SH SW, 19-27 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI,
//   28-37 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, 38-45 MUL MULH MULHSU MULHU DIV DIVU REM REMU.
//  Illegal: unlisted opcode; unlisted funct3/funct7 combo (incl. JALR funct3!=0, shift-imm funct7
//   other than 0000000/0100000); M ops when ENABLE_M=0. Illegal -> OP=0, FMT=7, RS/RD/IMM=0, flags 0.
//  Immediates: I {20{i31},i31:20}; S {20{i31},i31:25,i11:7}; B {19{i31},i31,i7,i30:25,i11:8,0};
//   U {i31:12,12'b0}; J {11{i31},i31,i19:12,i20,i30:21,0}. Shift-imm: IMM = {27'b0,i24:20}.
//  Counters increment on handoff only; wrap 2^CNT_W-1 -> 0.
// TESTING
//  addi x1,x2,-1 (0xFFF10093), OUT_READY=1 -> next cycle OP=19 FMT=1 RS1=2 RD=1 IMM=0xFFFFFFFF WR_RD=1.
//  beq x1,x2,-4 (0xFE208EE3) -> OP=5 FMT=3 RD=0 IMM=0xFFFFFFFC USE_RS1=USE_RS2=1 WR_RD=0.
//  ENABLE_M=0, mul x3,x1,x2 (0x022081B3) -> ILLEGAL=1 OP=0 FMT=7; ILLEGAL_CNT 0->1 on handoff.
//  Stream 4 beats, OUT_READY=0 for 3 cycles: IN_READY drops after 2 accepts; order and data kept.
//  2 beats buffered + FLUSH with IN_VALID=1 -> OUT_VALID=0 next cycle, no beat emitted, counters unchanged.
//  RSTN=0 mid-stream with full buffer -> OUT_VALID=0, counters=0; IN_READY=1 one cycle after release.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake and bundle signals between fetch, the decode stage and issue.
interface decode_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic [31:0]      out_imm;
   logic [2:0]       out_fmt;
   logic [5:0]       out_op;
   logic             out_use_rs1;
   logic             out_use_rs2;
   logic             out_wr_rd;
   logic             out_illegal;
   logic [CNT_W-1:0] decoded_cnt;
   logic [CNT_W-1:0] illegal_cnt;

   // Fetch/issue side view
   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
             out_fmt, out_op, out_use_rs1, out_use_rs2, out_wr_rd, out_illegal,
             decoded_cnt, illegal_cnt
   );

   // Decode stage view
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
             out_fmt, out_op, out_use_rs1, out_use_rs2, out_wr_rd, out_illegal,
             decoded_cnt, illegal_cnt
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode into a 2-entry (main + skid)
// output buffer, registered ready, flush on redirect, handoff statistics.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1,
   parameter int CNT_W    = 32
) (
   input logic           clk,
   input logic           rstn,
   decode_stage_if.slave bus
);
   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [31:0]     imm;
      logic [2:0]      fmt;
      logic [5:0]      op;
      logic            use_rs1;
      logic            use_rs2;
      logic            wr_rd;
      logic            illegal;
   } bundle_t;

   logic [31:0] ins;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [5:0]  op;
   logic [2:0]  fmt;
   bundle_t     dec, ent0, ent1;
   logic        v0, v1, rdy;
   logic        v0_n, v1_n;
   logic        push, pop;
   logic [CNT_W-1:0] dcnt, icnt;

   assign ins = bus.in_instr;
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];

   // Classify opcode/funct3/funct7 into op index and format; anything unlisted is op 0
   always_comb begin
      op  = 6'd0;
      fmt = FMT_ILL;
      case (ins[6:0])
         7'b0110111: begin op = 6'd1; fmt = FMT_U; end
         7'b0010111: begin op = 6'd2; fmt = FMT_U; end
         7'b1101111: begin op = 6'd3; fmt = FMT_J; end
         7'b1100111: begin fmt = FMT_I; op = (f3 == 3'd0) ? 6'd4 : 6'd0; end
         7'b1100011: begin
            fmt = FMT_B;
            case (f3)
               3'd0:    op = 6'd5;
               3'd1:    op = 6'd6;
               3'd4:    op = 6'd7;
               3'd5:    op = 6'd8;
               3'd6:    op = 6'd9;
               3'd7:    op = 6'd10;
               default: op = 6'd0;
            endcase
         end
         7'b0000011: begin
            fmt = FMT_I;
            case (f3)
               3'd0:    op = 6'd11;
               3'd1:    op = 6'd12;
               3'd2:    op = 6'd13;
               3'd4:    op = 6'd14;
               3'd5:    op = 6'd15;
               default: op = 6'd0;
            endcase
         end
         7'b0100011: begin
            fmt = FMT_S;
            case (f3)
               3'd0:    op = 6'd16;
               3'd1:    op = 6'd17;
               3'd2:    op = 6'd18;
               default: op = 6'd0;
            endcase
         end
         7'b0010011: begin
            fmt = FMT_I;
            case (f3)
               3'd0: op = 6'd19;
               3'd2: op = 6'd20;
               3'd3: op = 6'd21;
               3'd4: op = 6'd22;
               3'd6: op = 6'd23;
               3'd7: op = 6'd24;
               3'd1: op = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
               3'd5: op = (f7 == 7'b0000000) ? 6'd26 :
                          (f7 == 7'b0100000) ? 6'd27 : 6'd0;
               default: op = 6'd0;
            endcase
         end
         7'b0110011: begin
            fmt = FMT_R;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'd0:    op = 6'd28;
                  3'd1:    op = 6'd30;
                  3'd2:    op = 6'd31;
                  3'd3:    op = 6'd32;
                  3'd4:    op = 6'd33;
                  3'd5:    op = 6'd34;
                  3'd6:    op = 6'd36;
                  default: op = 6'd37;
               endcase
            end else if (f7 == 7'b0100000) begin
               op = (f3 == 3'd0) ? 6'd29 : (f3 == 3'd5) ? 6'd35 : 6'd0;
            end else if (f7 == 7'b0000001 && ENABLE_M) begin
               op = 6'd38 + {3'd0, f3};
            end
         end
         default: op = 6'd0;
      endcase
      if (op == 6'd0) fmt = FMT_ILL;
   end

   // Build the bundle: operand fields and immediate follow the format
   always_comb begin
      dec         = '0;
      dec.pc      = bus.in_pc;
      dec.op      = op;
      dec.fmt     = fmt;
      dec.illegal = (op == 6'd0);
      case (fmt)
         FMT_R: begin
            dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.rd = ins[11:7];
            dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
         end
         FMT_I: begin
            dec.rs1 = ins[19:15]; dec.rd = ins[11:7]; dec.use_rs1 = 1'b1;
            // shift-immediates carry only the 5-bit shamt
            if (op >= 6'd25 && op <= 6'd27) dec.imm = {27'b0, ins[24:20]};
            else                            dec.imm = {{20{ins[31]}}, ins[31:20]};
         end
         FMT_S: begin
            dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
            dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
            dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         end
         FMT_B: begin
            dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
            dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
            dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         FMT_U: begin
            dec.rd  = ins[11:7];
            dec.imm = {ins[31:12], 12'b0};
         end
         FMT_J: begin
            dec.rd  = ins[11:7];
            dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         default: ;
      endcase
      dec.wr_rd = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) &&
                  (dec.rd != 5'd0);
   end

   assign push = bus.in_valid & rdy;
   assign pop  = v0 & bus.out_ready;

   // Next occupancy: flush empties both, accept+handoff keeps occupancy
   always_comb begin
      v0_n = v0;
      v1_n = v1;
      if (bus.flush) begin
         v0_n = 1'b0;
         v1_n = 1'b0;
      end else if (pop && !push) begin
         if (v1) v1_n = 1'b0;
         else    v0_n = 1'b0;
      end else if (push && !pop) begin
         if (v0) v1_n = 1'b1;
         else    v0_n = 1'b1;
      end
   end

   // Buffer registers; ready mirrors next-cycle skid emptiness so it never
   // depends combinationally on out_ready
   always_ff @(posedge clk) begin
      if (!rstn) begin
         v0   <= 1'b0;
         v1   <= 1'b0;
         rdy  <= 1'b0;
         ent0 <= '0;
         ent1 <= '0;
      end else begin
         v0  <= v0_n;
         v1  <= v1_n;
         rdy <= ~v1_n;
         if (!bus.flush) begin
            if (pop && push)      ent0 <= dec;
            else if (pop && v1)   ent0 <= ent1;
            else if (push && !v0) ent0 <= dec;
            else if (push)        ent1 <= dec;
         end
      end
   end

   // Handoff statistics, including a handoff in a flush cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         dcnt <= '0;
         icnt <= '0;
      end else if (pop) begin
         dcnt <= dcnt + 1'b1;
         if (ent0.illegal) icnt <= icnt + 1'b1;
      end
   end

   assign bus.in_ready    = rdy;
   assign bus.out_valid   = v0;
   assign bus.out_pc      = ent0.pc;
   assign bus.out_rs1     = ent0.rs1;
   assign bus.out_rs2     = ent0.rs2;
   assign bus.out_rd      = ent0.rd;
   assign bus.out_imm     = ent0.imm;
   assign bus.out_fmt     = ent0.fmt;
   assign bus.out_op      = ent0.op;
   assign bus.out_use_rs1 = ent0.use_rs1;
   assign bus.out_use_rs2 = ent0.use_rs2;
   assign bus.out_wr_rd   = ent0.wr_rd;
   assign bus.out_illegal = ent0.illegal;
   assign bus.decoded_cnt = dcnt;
   assign bus.illegal_cnt = icnt;
endmodule
